cgol_gen_engine: RTL and testbench

//  Parametrised Game-of-Life generation engine for a WIDTH x HEIGHT grid with ping-pong state banks.

---
 rtl/cgol_pkg.sv | 24 ++
 rtl/cgol_row_rule.sv | 35 +++
 rtl/cgol_gen_engine.sv | 149 ++++++++++++++
 tb/tb_cgol_gen_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cgol_pkg.sv
// Shared types and helpers for the Game-of-Life generation engine.
//   engine_state_t : FSM encoding used by cgol_gen_engine
//   nbr_count      : live-neighbour count of a 3x3 window (centre excluded)
package cgol_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } engine_state_t;

    // Window layout: [8:6] = row above (left, centre, right),
    // [5:3] = own row, [2:0] = row below. Bit 4 is the cell itself.
    function automatic logic [3:0] nbr_count(input logic [8:0] win);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 9; k++) begin
            if (k != 4) n = n + {3'b000, win[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cgol_row_rule.sv
// Combinational Life rule for one full row.
//   above, cur, below : the three grid rows centred on the row being computed
//                       (already zeroed by the caller when outside the grid)
//   next_row          : the row's next-generation value
// Column neighbours wrap around when WRAP=1, otherwise read as dead.
module cgol_row_rule
    import cgol_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit WRAP  = 1'b1
) (
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    output logic [WIDTH-1:0] next_row
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        localparam int   LI = (i == 0) ? WIDTH - 1 : i - 1;
        localparam int   RI = (i == WIDTH - 1) ? 0 : i + 1;
        // Edge columns see their wrapped neighbour only on a torus.
        localparam logic LV = WRAP || (i != 0);
        localparam logic RV = WRAP || (i != WIDTH - 1);

        logic [8:0] win;
        logic [3:0] n;

        assign win = {above[LI] & LV, above[i], above[RI] & RV,
                      cur[LI]   & LV, cur[i],   cur[RI]   & RV,
                      below[LI] & LV, below[i], below[RI] & RV};
        assign n   = nbr_count(win);
        assign next_row[i] = (n == 4'd3) | (cur[i] & (n == 4'd2));
    end

endmodule

// File: rtl/cgol_gen_engine.sv
// Game-of-Life generation engine with ping-pong state banks.
// One row of the next generation is computed per cycle into the scratch bank;
// a one-cycle COMMIT then flips bank_sel so the display only ever sees whole
// generations.
//   ph1, reset          : clock (rising edge), async active-low reset
//   load_en/addr/data   : host writes a row of the committed bank (IDLE only)
//   start, gens, stop   : run control (gens==0 runs one generation)
//   rd_addr, rd_data    : combinational read of the committed bank
//   busy, done, stable  : run status
//   gen_count           : generations committed since reset (wraps)
module cgol_gen_engine
    import cgol_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int ROWBITS = 4,
    parameter int GENBITS = 16,
    parameter bit WRAP    = 1'b1
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ROWBITS-1:0] load_addr,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               start,
    input  logic [GENBITS-1:0] gens,
    input  logic               stop,
    input  logic [ROWBITS-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               busy,
    output logic               done,
    output logic               stable,
    output logic [GENBITS-1:0] gen_count
);

    localparam logic [ROWBITS-1:0] LAST_ROW = ROWBITS'(HEIGHT - 1);

    engine_state_t state, state_nxt;

    logic                         bank_sel;
    logic [HEIGHT-1:0][WIDTH-1:0] bank0, bank1, cur_bank;
    logic [ROWBITS-1:0]           row, up_idx, dn_idx;
    logic [GENBITS-1:0]           remaining;
    logic                         diff, stop_seen;
    logic [WIDTH-1:0]             above, cur_row, below, new_row;
    logic                         last_row, finish, rd_ok, ld_ok;

    // bank_sel=0: bank0 is committed (displayed), bank1 is scratch.
    assign cur_bank = bank_sel ? bank1 : bank0;

    // Address range guards are only needed when HEIGHT is not a power of two.
    if (HEIGHT == (1 << ROWBITS)) begin : g_full
        assign rd_ok = 1'b1;
        assign ld_ok = 1'b1;
    end else begin : g_part
        assign rd_ok = (int'(rd_addr)   < HEIGHT);
        assign ld_ok = (int'(load_addr) < HEIGHT);
    end

    assign rd_data = rd_ok ? cur_bank[rd_addr] : '0;

    // Neighbour rows of the row being computed.
    assign last_row = (row == LAST_ROW);
    assign up_idx   = (row == '0) ? LAST_ROW : row - 1'b1;
    assign dn_idx   = last_row ? '0 : row + 1'b1;
    assign cur_row  = cur_bank[row];
    assign above    = (WRAP || (row != '0)) ? cur_bank[up_idx] : '0;
    assign below    = (WRAP || !last_row)   ? cur_bank[dn_idx] : '0;

    cgol_row_rule #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_rule (
        .above    (above),
        .cur      (cur_row),
        .below    (below),
        .next_row (new_row)
    );

    // A stop arriving during COMMIT itself still ends the run at this boundary.
    assign finish = (remaining == GENBITS'(1)) || !diff || stop_seen || stop;

    assign busy = (state == RUN) || (state == COMMIT);
    assign done = (state == DONE);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_row) state_nxt = COMMIT;
            COMMIT:  state_nxt = finish ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            bank0     <= '0;
            bank1     <= '0;
            bank_sel  <= 1'b0;
            row       <= '0;
            remaining <= '0;
            diff      <= 1'b0;
            stop_seen <= 1'b0;
            stable    <= 1'b0;
            gen_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en && ld_ok) begin
                        if (bank_sel) bank1[load_addr] <= load_data;
                        else          bank0[load_addr] <= load_data;
                    end
                    if (start) begin
                        remaining <= (gens == '0) ? GENBITS'(1) : gens;
                        stable    <= 1'b0;
                        stop_seen <= 1'b0;
                        diff      <= 1'b0;
                        row       <= '0;
                    end
                end
                RUN: begin
                    if (bank_sel) bank0[row] <= new_row;
                    else          bank1[row] <= new_row;
                    if (new_row != cur_row) diff <= 1'b1;
                    row <= last_row ? '0 : row + 1'b1;
                end
                COMMIT: begin
                    bank_sel  <= ~bank_sel;
                    gen_count <= gen_count + 1'b1;
                    remaining <= remaining - 1'b1;
                    diff      <= 1'b0;
                    if (!diff) stable <= 1'b1;
                end
                default: ;
            endcase
            // Latched so a single-cycle pulse anywhere in a generation counts;
            // cleared again when the next run is accepted.
            if (stop && (state != IDLE)) stop_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cgol_gen_engine.sv
// Directed bench for cgol_gen_engine: three instances (8x8 torus, 8x8 dead
// border, 16x16 torus) share one control bus gated by sel.
module tb_cgol_gen_engine;

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic        load_en, start, stop;
    logic [3:0]  load_addr, rd_addr;
    logic [15:0] load_data, gens;
    logic [1:0]  sel;

    logic [7:0]  rd_a, rd_b;
    logic [15:0] rd_c, gc_a, gc_b, gc_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic        stab_a, stab_b, stab_c;

    logic [15:0] rd_m, gc_m;
    logic        busy_m, done_m, stab_m;

    logic [15:0] exp_g [16];
    int          checks = 0;
    int          failures = 0;

    always #5 ph1 = ~ph1;

    cgol_gen_engine #(.WIDTH(8), .HEIGHT(8), .ROWBITS(3), .GENBITS(16), .WRAP(1'b1)) u_a (
        .ph1(ph1), .reset(reset), .load_en(load_en && sel == 2'd0), .load_addr(load_addr[2:0]),
        .load_data(load_data[7:0]), .start(start && sel == 2'd0), .gens(gens),
        .stop(stop && sel == 2'd0), .rd_addr(rd_addr[2:0]), .rd_data(rd_a), .busy(busy_a),
        .done(done_a), .stable(stab_a), .gen_count(gc_a));

    cgol_gen_engine #(.WIDTH(8), .HEIGHT(8), .ROWBITS(3), .GENBITS(16), .WRAP(1'b0)) u_b (
        .ph1(ph1), .reset(reset), .load_en(load_en && sel == 2'd1), .load_addr(load_addr[2:0]),
        .load_data(load_data[7:0]), .start(start && sel == 2'd1), .gens(gens),
        .stop(stop && sel == 2'd1), .rd_addr(rd_addr[2:0]), .rd_data(rd_b), .busy(busy_b),
        .done(done_b), .stable(stab_b), .gen_count(gc_b));

    cgol_gen_engine #(.WIDTH(16), .HEIGHT(16), .ROWBITS(4), .GENBITS(16), .WRAP(1'b1)) u_c (
        .ph1(ph1), .reset(reset), .load_en(load_en && sel == 2'd2), .load_addr(load_addr),
        .load_data(load_data), .start(start && sel == 2'd2), .gens(gens),
        .stop(stop && sel == 2'd2), .rd_addr(rd_addr), .rd_data(rd_c), .busy(busy_c),
        .done(done_c), .stable(stab_c), .gen_count(gc_c));

    always_comb begin
        rd_m = {8'h00, rd_a}; gc_m = gc_a; busy_m = busy_a; done_m = done_a; stab_m = stab_a;
        case (sel)
            2'd1: begin rd_m = {8'h00, rd_b}; gc_m = gc_b; busy_m = busy_b; done_m = done_b; stab_m = stab_b; end
            2'd2: begin rd_m = rd_c; gc_m = gc_c; busy_m = busy_c; done_m = done_c; stab_m = stab_c; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_exp();
        for (int r = 0; r < 16; r++) exp_g[r] = '0;
    endtask

    task automatic load_grid(input int rows);
        for (int r = 0; r < rows; r++) begin
            @(negedge ph1);
            load_en = 1'b1; load_addr = 4'(r); load_data = exp_g[r];
        end
        @(negedge ph1);
        load_en = 1'b0;
    endtask

    task automatic chk_grid(input string tag, input int rows);
        for (int r = 0; r < rows; r++) begin
            @(negedge ph1);
            rd_addr = 4'(r);
            #1;
            chk($sformatf("%s_r%0d", tag, r), 32'(rd_m), 32'(exp_g[r]));
        end
    endtask

    // Starts a run and counts busy cycles until done. proto injects an ignored
    // load/start early in generation 1 and a one-cycle stop in generation 2.
    task automatic run_gen(input int g, input int limit, input bit proto, output int bcyc);
        bit seen;
        seen = 1'b0;
        bcyc = 0;
        @(negedge ph1); gens = 16'(g); start = 1'b1;
        @(negedge ph1); start = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (done_m) begin seen = 1'b1; break; end
            if (busy_m) bcyc++;
            if (proto) begin
                load_en   = (bcyc == 3);
                start     = (bcyc == 3);
                load_addr = 4'd0;
                load_data = 16'hFFFF;
                stop      = (bcyc == 12);
            end
            @(negedge ph1);
        end
        load_en = 1'b0; start = 1'b0; stop = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            @(negedge ph1);
            chk("done_pulse", 32'(done_m), 32'd0);
            chk("busy_after", 32'(busy_m), 32'd0);
        end
    endtask

    initial begin
        int  bc;
        bit  seen;
        load_en = 0; start = 0; stop = 0; load_addr = 0; load_data = 0;
        gens = 0; rd_addr = 0; sel = 2'd0;
        clr_exp();

        // Reset state
        repeat (3) @(negedge ph1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_stable", 32'(stab_a), 0);
        chk("rst_gc", 32'(gc_a), 0);
        reset = 1'b1;
        chk_grid("rst", 8);

        // Blinker, one generation
        clr_exp();
        exp_g[3] = 16'h10; exp_g[4] = 16'h10; exp_g[5] = 16'h10;
        load_grid(8);
        run_gen(1, 50, 1'b0, bc);
        chk("blk_busy", 32'(bc), 9);
        chk("blk_gc", 32'(gc_m), 1);
        clr_exp();
        exp_g[4] = 16'h38;
        chk_grid("blk", 8);

        // Glider travels all the way around the 8x8 torus in 32 generations
        clr_exp();
        exp_g[0] = 16'h02; exp_g[1] = 16'h04; exp_g[2] = 16'h07;
        load_grid(8);
        run_gen(32, 400, 1'b0, bc);
        chk("gld_busy", 32'(bc), 288);
        chk("gld_gc", 32'(gc_m), 33);
        chk("gld_stable", 32'(stab_m), 0);
        chk_grid("gld", 8);

        // Protocol: ignored load/start while busy, stop pulse in generation 2
        clr_exp();
        exp_g[3] = 16'h10; exp_g[4] = 16'h10; exp_g[5] = 16'h10;
        load_grid(8);
        run_gen(5, 100, 1'b1, bc);
        chk("prt_busy", 32'(bc), 18);
        chk("prt_gc", 32'(gc_m), 35);
        chk("prt_stable", 32'(stab_m), 0);
        chk_grid("prt", 8);

        // Dead border: corner block plus clipped blinker
        sel = 2'd1;
        clr_exp();
        exp_g[0] = 16'hE3; exp_g[1] = 16'h03;
        load_grid(8);
        run_gen(1, 50, 1'b0, bc);
        chk("dead_busy", 32'(bc), 9);
        chk("dead_gc", 32'(gc_m), 1);
        clr_exp();
        exp_g[0] = 16'h43; exp_g[1] = 16'h43;
        chk_grid("dead", 8);

        // Still life ends a long run after one generation
        sel = 2'd2;
        clr_exp();
        exp_g[7] = 16'h0180; exp_g[8] = 16'h0180;
        load_grid(16);
        run_gen(100, 200, 1'b0, bc);
        chk("stab_busy", 32'(bc), 17);
        chk("stab_flag", 32'(stab_m), 1);
        chk("stab_gc", 32'(gc_m), 1);
        chk_grid("stab", 16);

        // Reset mid-run on the 8x8 torus (bank holds the blinker)
        sel = 2'd0;
        @(negedge ph1); gens = 16'd10; start = 1'b1;
        @(negedge ph1); start = 1'b0;
        repeat (4) @(negedge ph1);
        chk("mid_busy_pre", 32'(busy_a), 1);
        reset = 1'b0;
        @(negedge ph1);
        reset = 1'b1;
        chk("mid_busy", 32'(busy_a), 0);
        chk("mid_gc", 32'(gc_a), 0);
        chk("mid_gc_c", 32'(gc_c), 0);
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge ph1);
            if (done_a || busy_a) seen = 1'b1;
        end
        chk("mid_quiet", 32'(seen), 0);
        clr_exp();
        chk_grid("mid", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
